ifu_fetch: RTL and testbench

//  Instruction fetch stage feeding the instruction decoder: owns the PC register, fetches one word per

---
 rtl/ifu_fetch_pkg.sv | 25 ++
 rtl/ifu_npc_calc.sv | 30 +++
 rtl/ifu_fetch.sv | 129 ++++++++++++
 tb/tb_ifu_fetch.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_pkg.sv
// =============================================================================
// Module      : ifu_fetch_pkg
// Description : Shared next-PC select codes and helpers for the fetch stage.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package ifu_fetch_pkg;

    typedef enum logic [2:0] {
        NPC_PLUS4  = 3'b000,
        NPC_BRANCH = 3'b001,
        NPC_JUMP   = 3'b010,
        NPC_JALR   = 3'b100
    } npc_op_e;

    localparam logic [31:0] C_PC_STEP = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ifu_npc_calc.sv
// =============================================================================
// Module      : ifu_npc_calc
// Description : Combinational next-PC target from the decoder's select code.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module ifu_npc_calc
    import ifu_fetch_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [2:0]  npc_op_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] alu_out_i,
    output logic [31:0] next_pc_o
);

    always_comb begin
        next_pc_o = pc_i + C_PC_STEP;
        case (npc_op_i)
            NPC_BRANCH,
            NPC_JUMP:   next_pc_o = pc_i + imm_i;
            NPC_JALR:   next_pc_o = {alu_out_i[31:1], 1'b0};
            default:    next_pc_o = pc_i + C_PC_STEP;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ifu_fetch.sv
// =============================================================================
// Module      : ifu_fetch
// Description : PC owner and single-word req/ack fetch FSM feeding decode.
//               Optional IFU_MISALIGN_TRAP_EN: misaligned target traps.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  npc_op,
    input  logic [31:0] imm,
    input  logic [31:0] alu_out,
    input  logic        commit,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misalign
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
`ifdef IFU_MISALIGN_TRAP_EN
        ST_EXEC  = 2'd2,
        ST_TRAP  = 2'd3
`else
        ST_EXEC  = 2'd2
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] next_pc_w;

    ifu_npc_calc u_npc_calc (
        .pc_i      (pc_q),
        .npc_op_i  (npc_op),
        .imm_i     (imm),
        .alu_out_i (alu_out),
        .next_pc_o (next_pc_w)
    );

`ifdef IFU_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    always_ff @(posedge clk) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= misalign_d;
    end

    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
`ifdef IFU_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            ST_BOOT:  state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (commit) begin
`ifdef IFU_MISALIGN_TRAP_EN
                    // PC stays on the faulting instruction for the trap handler
                    if (next_pc_w[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        state_d    = ST_TRAP;
                    end else begin
                        pc_d    = next_pc_w;
                        state_d = ST_FETCH;
                    end
`else
                    pc_d    = word_align(next_pc_w);
                    state_d = ST_FETCH;
`endif
                end
            end
`ifdef IFU_MISALIGN_TRAP_EN
            ST_TRAP:  state_d = ST_TRAP;
`endif
            default:  state_d = ST_BOOT;
        endcase
    end

    assign imem_req    = (state_q == ST_FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == ST_EXEC);
    assign instr       = instr_valid ? instr_q : NOP_INSTR;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + C_PC_STEP;

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch.sv
// =============================================================================
// Module      : tb_ifu_fetch
// Description : Randomized scoreboard bench for ifu_fetch with reference PC model.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_ifu_fetch;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] C_NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  npc_op = 3'd0;
    logic [31:0] imm = 32'd0;
    logic [31:0] alu_out = 32'd0;
    logic        commit = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_ack = 1'b0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign;

    ifu_fetch #(
        .RESET_PC  (C_RESET_PC),
        .NOP_INSTR (C_NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .npc_op      (npc_op),
        .imm         (imm),
        .alu_out     (alu_out),
        .commit      (commit),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    logic [31:0] addr_q[$];
    exp_t        exp_q[$];
    logic [31:0] m_pc = C_RESET_PC;
    bit          m_trapped = 1'b0;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic summary_and_finish();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    // Raw target address implied by the ISA semantics of each select code
    function automatic logic [31:0] ref_target(input logic [2:0] op, input logic [31:0] cur,
                                               input logic [31:0] im, input logic [31:0] alu);
        case (op)
            3'b001, 3'b010: return cur + im;
            3'b100:         return alu & 32'hFFFF_FFFE;
            default:        return cur + 32'd4;
        endcase
    endfunction

    // Monitor: compares every new fetch request and every newly valid instruction
    bit prev_req = 1'b0;
    bit prev_valid = 1'b0;
    always @(posedge clk) begin
        #2;
        if (imem_req === 1'b1 && !prev_req) begin
            if (addr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_fetch: got addr %h expected no request", imem_addr);
            end else begin
                check("fetch_addr", imem_addr, addr_q.pop_front());
            end
        end
        if (instr_valid === 1'b1 && !prev_valid) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_valid: got instr %h expected no instruction", instr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("instr", instr, e.ins);
                check("pc", pc, e.pc);
                check("pc_plus4", pc_plus4, e.pc + 32'd4);
            end
        end
        prev_req   = (imem_req === 1'b1);
        prev_valid = (instr_valid === 1'b1);
    end

    // Reset (optionally with an ack landing in the reset cycle and in BOOT); starts at a negedge
    task automatic reset_dut(input bit with_ack);
        rst        = 1'b1;
        commit     = 1'b0;
        imem_ack   = with_ack;
        imem_rdata = $urandom;
        m_pc       = C_RESET_PC;
        m_trapped  = 1'b0;
        addr_q.push_back(C_RESET_PC);
        @(negedge clk);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, C_NOP);
        check("rst_pc", pc, C_RESET_PC);
        check("rst_misalign", {31'd0, misalign}, 32'd0);
        rst        = 1'b0;
        imem_rdata = $urandom;
        @(negedge clk);
        imem_ack   = 1'b0;
    endtask

    // One fetch/commit pair; entered and left at a negedge
    task automatic do_txn(input logic [2:0] op, input logic [31:0] im, input logic [31:0] alu,
                          input int ack_wait, input int cmt_wait, input bit junk);
        int n;
        logic [31:0] tgt;
        n = 0;
        while (imem_req !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 20) begin
                checks++; errors++;
                $display("FAIL req_timeout: got no imem_req expected one within 20 cycles");
                summary_and_finish();
            end
        end
        for (int i = 0; i < ack_wait; i++) begin
            commit  = junk;
            npc_op  = 3'($urandom);
            imm     = $urandom;
            alu_out = $urandom;
            @(negedge clk);
            commit  = 1'b0;
        end
        imem_ack   = 1'b1;
        imem_rdata = $urandom;
        exp_q.push_back('{m_pc, imem_rdata});
        @(negedge clk);
        imem_ack   = 1'b0;
        for (int i = 0; i < cmt_wait; i++) begin
            imem_ack   = junk;
            imem_rdata = $urandom;
            @(negedge clk);
            imem_ack   = 1'b0;
        end
        commit  = 1'b1;
        npc_op  = op;
        imm     = im;
        alu_out = alu;
        tgt     = ref_target(op, m_pc, im, alu);
`ifdef IFU_MISALIGN_TRAP_EN
        if (tgt[1:0] != 2'b00) begin
            m_trapped = 1'b1;
        end else begin
            m_pc = tgt;
            addr_q.push_back(m_pc);
        end
`else
        m_pc = {tgt[31:2], 2'b00};
        addr_q.push_back(m_pc);
`endif
        @(negedge clk);
        commit  = 1'b0;
        npc_op  = 3'($urandom);
        imm     = $urandom;
        alu_out = $urandom;
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] r_imm, r_alu;
        @(negedge clk);
        reset_dut(1'b0);

        do_txn(3'b000, 32'd0, 32'd0, 2, 0, 1'b0);
        do_txn(3'b100, 32'd0, 32'h0000_0010, 1, 1, 1'b1);
        do_txn(3'b001, 32'hFFFF_FFF8, 32'd0, 0, 2, 1'b1);
        do_txn(3'b100, 32'd0, 32'h0000_0010, 0, 0, 1'b0);
        do_txn(3'b000, 32'd0, 32'd0, 3, 1, 1'b1);
        do_txn(3'b100, 32'd0, 32'h0000_0010, 0, 0, 1'b0);
        do_txn(3'b100, 32'd0, 32'h0000_0123, 1, 0, 1'b0);
`ifdef IFU_MISALIGN_TRAP_EN
        repeat (3) @(negedge clk);
        check("trap_misalign", {31'd0, misalign}, 32'd1);
        check("trap_req", {31'd0, imem_req}, 32'd0);
        check("trap_valid", {31'd0, instr_valid}, 32'd0);
        check("trap_pc", pc, 32'h0000_0010);
        reset_dut(1'b0);
`endif
        do_txn(3'b100, 32'd0, 32'hFFFF_FFFC, 0, 1, 1'b0);
        do_txn(3'b000, 32'd0, 32'd0, 1, 0, 1'b0);
        do_txn(3'b011, 32'h0000_0100, 32'h0000_0200, 0, 0, 1'b0);
        for (int i = 0; i < 4; i++) do_txn(3'b000, 32'd0, 32'd0, 0, 0, 1'b0);

        // reset mid-fetch while the memory acks in the same cycle
        reset_dut(1'b1);
        do_txn(3'b010, 32'h0000_0040, 32'd0, 0, 0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 4))
                0:       op = 3'b000;
                1:       op = 3'b001;
                2:       op = 3'b010;
                3:       op = 3'b100;
                default: op = 3'($urandom);
            endcase
            r_imm = $urandom;
            r_alu = $urandom;
`ifdef IFU_MISALIGN_TRAP_EN
            r_imm = r_imm & 32'hFFFF_FFFC;
            r_alu = r_alu & 32'hFFFF_FFFC;
`endif
            do_txn(op, r_imm, r_alu, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
            if (i == 30) reset_dut(1'($urandom));
        end

        repeat (4) @(negedge clk);
        check("addr_q_drained", 32'(addr_q.size()), 32'd0);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("final_req", {31'd0, imem_req}, {31'd0, ~m_trapped});
        summary_and_finish();
    end

endmodule

`default_nettype wire
